// File: rtl/apb_fifo_slave.sv
// Zero-wait-state APB completer with CTRL/STATUS/DATA/SCRATCH registers.
// The DATA register is a push/pop window onto a DEPTH-entry FIFO with a level interrupt.
module apb_fifo_slave #(
   parameter int ADDRW = 32,
   parameter int DATAW = 32,
   parameter int DEPTH = 8
) (
   input  logic             pclk,
   input  logic             presetn,
   input  logic [ADDRW-1:0] paddr,
   input  logic             psel,
   input  logic             penable,
   input  logic             pwrite,
   input  logic [DATAW-1:0] pwdata,
   output logic [DATAW-1:0] prdata,
   output logic             irq
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
   typedef enum logic [1:0] {A_CTRL, A_STATUS, A_DATA, A_SCRATCH} addr_t;

   state_t           state;
   addr_t            reg_sel;
   logic             ctrl_en, ctrl_ie;
   logic [DATAW-1:0] scratch;
   logic [DATAW-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr, wr_ptr;
   logic [CW-1:0]    cnt;
   logic             ovf, udf;

   logic             empty, full;
   logic             setup_edge, access_edge;
   logic             wr_ctrl, wr_data, wr_scratch, rd_data;
   logic             do_clr, do_push, do_pop, set_ovf, set_udf;
   logic [PW-1:0]    rd_n, wr_n;
   logic [CW-1:0]    cnt_n;
   logic             ovf_n, udf_n, en_n, ie_n;
   logic [15:0]      stat16;
   logic [DATAW-1:0] ctrl_rd, status, rd_mux;
   logic             unused_paddr;

   assign unused_paddr = ^paddr;
   assign reg_sel      = addr_t'(paddr[3:2]);
   assign empty        = (cnt == '0);
   assign full         = (cnt == CW'(DEPTH));

   // A setup phase seen while already in SETUP is an abort, not a new setup.
   assign setup_edge  = psel & ~penable & (state != SETUP);
   assign access_edge = psel &  penable & (state == SETUP);

   assign wr_ctrl    = access_edge &  pwrite & (reg_sel == A_CTRL);
   assign wr_data    = access_edge &  pwrite & (reg_sel == A_DATA);
   assign wr_scratch = access_edge &  pwrite & (reg_sel == A_SCRATCH);
   assign rd_data    = access_edge & ~pwrite & (reg_sel == A_DATA);

   assign do_clr  = wr_ctrl & pwdata[2];
   assign do_push = wr_data & ctrl_en & ~full;
   assign set_ovf = wr_data & ctrl_en &  full;
   assign do_pop  = rd_data & ctrl_en & ~empty;
   assign set_udf = rd_data & ctrl_en &  empty;

   always_comb begin
      rd_n  = rd_ptr;
      wr_n  = wr_ptr;
      cnt_n = cnt;
      ovf_n = ovf;
      udf_n = udf;
      en_n  = ctrl_en;
      ie_n  = ctrl_ie;
      if (do_push) begin
         wr_n  = wr_ptr + PW'(1);
         cnt_n = cnt + CW'(1);
      end
      if (do_pop) begin
         rd_n  = rd_ptr + PW'(1);
         cnt_n = cnt - CW'(1);
      end
      if (set_ovf) ovf_n = 1'b1;
      if (set_udf) udf_n = 1'b1;
      if (wr_ctrl) begin
         en_n = pwdata[0];
         ie_n = pwdata[1];
      end
      // Flush overrides any FIFO update on the same edge.
      if (do_clr) begin
         rd_n  = '0;
         wr_n  = '0;
         cnt_n = '0;
         ovf_n = 1'b0;
         udf_n = 1'b0;
      end
   end

   always_comb begin
      stat16      = '0;
      stat16[0]   = empty;
      stat16[1]   = full;
      stat16[2]   = ovf;
      stat16[3]   = udf;
      stat16[15:8] = 8'(cnt);
      status      = DATAW'(stat16);
      ctrl_rd     = '0;
      ctrl_rd[0]  = ctrl_en;
      ctrl_rd[1]  = ctrl_ie;
      unique case (reg_sel)
         A_CTRL:    rd_mux = ctrl_rd;
         A_STATUS:  rd_mux = status;
         A_DATA:    rd_mux = (ctrl_en & empty) ? '0 : mem[rd_ptr];
         A_SCRATCH: rd_mux = scratch;
         default:   rd_mux = '0;
      endcase
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state   <= IDLE;
         prdata  <= '0;
         irq     <= 1'b0;
         ctrl_en <= 1'b0;
         ctrl_ie <= 1'b0;
         scratch <= '0;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         cnt     <= '0;
         ovf     <= 1'b0;
         udf     <= 1'b0;
      end else begin
         unique case (state)
            IDLE:    state <= (psel & ~penable) ? SETUP  : IDLE;
            SETUP:   state <= (psel &  penable) ? ACCESS : IDLE;
            ACCESS:  state <= (psel & ~penable) ? SETUP  : IDLE;
            default: state <= IDLE;
         endcase
         if (setup_edge && !pwrite) prdata <= rd_mux;
         if (wr_scratch) scratch <= pwdata;
         ctrl_en <= en_n;
         ctrl_ie <= ie_n;
         rd_ptr  <= rd_n;
         wr_ptr  <= wr_n;
         cnt     <= cnt_n;
         ovf     <= ovf_n;
         udf     <= udf_n;
         irq     <= ie_n & ((cnt_n != '0) | ovf_n | udf_n);
      end
   end

   always_ff @(posedge pclk) begin
      if (do_push) mem[wr_ptr] <= pwdata;
   end

endmodule

// File: tb/tb_apb_fifo_slave.sv
// Scoreboarded bench for apb_fifo_slave: expected read data is queued when a read is
// issued and compared when the access phase completes.
module tb_apb_fifo_slave;

   localparam int DEPTH = 8;
   localparam logic [31:0] A_CTRL    = 32'h0;
   localparam logic [31:0] A_STATUS  = 32'h4;
   localparam logic [31:0] A_DATA    = 32'h8;
   localparam logic [31:0] A_SCRATCH = 32'hC;

   logic        pclk = 1'b0;
   logic        presetn;
   logic [31:0] paddr;
   logic        psel, penable, pwrite;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        irq;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q[$];
   string       tag_q[$];

   apb_fifo_slave #(.ADDRW(32), .DATAW(32), .DEPTH(DEPTH)) dut (
      .pclk(pclk), .presetn(presetn), .paddr(paddr), .psel(psel), .penable(penable),
      .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .irq(irq)
   );

   always #5 pclk = ~pclk;

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge pclk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
      @(negedge pclk);
      penable = 1'b1;
      @(negedge pclk);
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic apb_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
      logic [31:0] e;
      string       t;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      @(negedge pclk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a; pwdata = '0;
      @(negedge pclk);
      penable = 1'b1;
      @(negedge pclk);
      psel = 1'b0; penable = 1'b0;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, prdata, e);
   endtask

   initial begin
      presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0;
      repeat (3) @(negedge pclk);
      check("rst_prdata", prdata, 32'h0);
      check("rst_irq", {31'b0, irq}, 32'h0);
      presetn = 1'b1;

      // reset state
      apb_read(A_STATUS, 32'h0000_0001, "t1_status");
      check("t1_irq", {31'b0, irq}, 32'h0);
      apb_read(A_SCRATCH, 32'h0, "t1_scratch");

      // scratch and read-only status
      apb_write(A_SCRATCH, 32'hA5A5_5A5A);
      apb_read(32'h1000_000C, 32'hA5A5_5A5A, "t2_scratch_hi_addr");
      apb_write(A_STATUS, 32'hFFFF_FFFF);
      apb_read(A_STATUS, 32'h0000_0001, "t2_status_ro");

      // basic push/pop with interrupt
      apb_write(A_CTRL, 32'h3);
      apb_read(A_CTRL, 32'h3, "t3_ctrl");
      apb_write(A_DATA, 32'h11);
      apb_write(A_DATA, 32'h22);
      apb_write(A_DATA, 32'h33);
      apb_read(A_STATUS, 32'h0000_0300, "t3_status_cnt3");
      check("t3_irq_on", {31'b0, irq}, 32'h1);
      apb_read(A_DATA, 32'h11, "t3_pop0");
      apb_read(A_DATA, 32'h22, "t3_pop1");
      apb_read(A_DATA, 32'h33, "t3_pop2");
      apb_read(A_STATUS, 32'h0000_0001, "t3_status_empty");
      check("t3_irq_off", {31'b0, irq}, 32'h0);

      // overflow and pointer wrap (pointers start mid-array here)
      apb_write(A_CTRL, 32'h1);
      for (int i = 0; i <= DEPTH; i++) apb_write(A_DATA, 32'h100 + i);
      apb_read(A_STATUS, 32'h0000_0806, "t4_status_full_ovf");
      check("t4_irq_masked", {31'b0, irq}, 32'h0);
      for (int i = 0; i < DEPTH; i++) apb_read(A_DATA, 32'h100 + i, $sformatf("t4_pop%0d", i));
      apb_read(A_STATUS, 32'h0000_0005, "t4_status_after");

      // underflow, irq from flags, clear
      apb_read(A_DATA, 32'h0, "t5_pop_empty");
      apb_read(A_STATUS, 32'h0000_000D, "t5_status_udf");
      apb_write(A_CTRL, 32'h3);
      check("t5_irq_flags", {31'b0, irq}, 32'h1);
      apb_write(A_CTRL, 32'h5);
      check("t5_irq_clr", {31'b0, irq}, 32'h0);
      apb_read(A_STATUS, 32'h0000_0001, "t5_status_clr");
      apb_read(A_CTRL, 32'h1, "t5_ctrl_clr_reads0");
      apb_write(A_CTRL, 32'h0);
      apb_write(A_DATA, 32'h77);
      apb_read(A_STATUS, 32'h0000_0001, "t5_push_disabled");
      apb_write(A_CTRL, 32'h1);
      apb_write(A_DATA, 32'h99);
      apb_write(A_CTRL, 32'h0);
      apb_read(A_DATA, 32'h99, "t5_peek");
      apb_read(A_STATUS, 32'h0000_0100, "t5_peek_no_pop");
      apb_write(A_CTRL, 32'h1);
      apb_read(A_DATA, 32'h99, "t5_pop_after_peek");
      apb_read(A_STATUS, 32'h0000_0001, "t5_status_final");

      // protocol violations
      apb_write(A_SCRATCH, 32'h0000_1234);
      @(negedge pclk);
      psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = A_SCRATCH; pwdata = 32'hDEAD_0001;
      @(negedge pclk);
      psel = 1'b0; penable = 1'b0;
      apb_read(A_SCRATCH, 32'h0000_1234, "t6_no_setup");
      @(negedge pclk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = A_SCRATCH; pwdata = 32'hDEAD_0002;
      @(negedge pclk);
      psel = 1'b0; penable = 1'b1;
      @(negedge pclk);
      penable = 1'b0;
      apb_read(A_SCRATCH, 32'h0000_1234, "t6_abort");

      // reset during access phase of a push
      apb_write(A_CTRL, 32'h3);
      apb_write(A_DATA, 32'h55);
      check("t6_irq_pre", {31'b0, irq}, 32'h1);
      @(negedge pclk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = A_DATA; pwdata = 32'h66;
      @(negedge pclk);
      penable = 1'b1;
      #2 presetn = 1'b0;
      @(negedge pclk);
      psel = 1'b0; penable = 1'b0;
      check("t6_rst_prdata", prdata, 32'h0);
      check("t6_rst_irq", {31'b0, irq}, 32'h0);
      @(negedge pclk);
      presetn = 1'b1;
      apb_read(A_STATUS, 32'h0000_0001, "t6_status_after_rst");
      apb_read(A_CTRL, 32'h0, "t6_ctrl_after_rst");
      check("t6_irq_after_rst", {31'b0, irq}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
